// File: rtl/regbus_cmd_master_pkg.sv
// Shared definitions for the byte-stream register-bus command master.
package regbus_cmd_master_pkg;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RD_WAIT,
        TX
    } state_t;

    function automatic int byte_cnt_w(input int nb);
        return $clog2(nb + 1);
    endfunction

endpackage

// File: rtl/regbus_tx_ser.sv
// Loads a bus word and streams it out MSB byte first over valid/ready.
module regbus_tx_ser
    import regbus_cmd_master_pkg::*;
#(
    parameter int DATAW = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic [DATAW-1:0] word,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             done
);

    localparam int NB   = DATAW / 8;
    localparam int CNTW = byte_cnt_w(NB);

    logic [DATAW-1:0] shreg;
    logic [CNTW-1:0]  left;
    logic             hs;

    assign hs      = tx_valid & tx_ready;
    assign tx_data = shreg[DATAW-1 -: 8];
    assign done    = hs && (left == CNTW'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg    <= '0;
            left     <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= word;
            left     <= CNTW'(NB);
            tx_valid <= 1'b1;
        end else if (hs) begin
            shreg <= shreg << 8;
            left  <= left - 1'b1;
            if (left == CNTW'(1))
                tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regbus_cmd_master.sv
// Framed byte-stream command decoder driving a simple register bus.
// Writes: 0x57, addr, NB data bytes.  Reads: 0x52, addr -> NB response bytes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an opcode; unknown opcodes pulse o_err
// ADDR    | waiting for the address byte
// WDATA   | shifting in NB write-data bytes
// WRITE   | o_we asserted for this single cycle
// RD_WAIT | counting out slave read latency, then capturing i_rdata
// TX      | response bytes streaming out of the serializer
module regbus_cmd_master
    import regbus_cmd_master_pkg::*;
#(
    parameter int DATAW  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    output logic             o_rx_ready,
    output logic             o_tx_valid,
    output logic [7:0]       o_tx_data,
    input  logic             i_tx_ready,
    output logic             o_we,
    output logic [7:0]       o_addr,
    output logic [DATAW-1:0] o_wdata,
    input  logic [DATAW-1:0] i_rdata,
    output logic             o_err
);

    localparam int NB   = DATAW / 8;
    localparam int CNTW = byte_cnt_w(NB);
    localparam int LATW = $clog2(RD_LAT + 1);

    state_t             state;
    logic               is_wr;
    logic [CNTW-1:0]    byte_cnt;
    logic [LATW-1:0]    lat_cnt;
    logic               rx_hs;
    logic [DATAW+7:0]   wdata_shift;
    logic               tx_load;
    logic               tx_done;

    // Held low through reset so nothing is accepted while the FSM is being cleared.
    assign o_rx_ready  = !i_rst && (state == IDLE || state == ADDR || state == WDATA);
    assign rx_hs       = i_rx_valid && o_rx_ready;
    assign wdata_shift = {o_wdata, i_rx_data};
    assign tx_load     = (state == RD_WAIT) && (lat_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            byte_cnt <= '0;
            lat_cnt  <= '0;
            o_we     <= 1'b0;
            o_err    <= 1'b0;
            o_addr   <= '0;
            o_wdata  <= '0;
        end else begin
            o_we  <= 1'b0;
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_hs) begin
                        if (i_rx_data == OP_WR) begin
                            is_wr <= 1'b1;
                            state <= ADDR;
                        end else if (i_rx_data == OP_RD) begin
                            is_wr <= 1'b0;
                            state <= ADDR;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (rx_hs) begin
                        o_addr   <= i_rx_data;
                        byte_cnt <= '0;
                        lat_cnt  <= LATW'(RD_LAT);
                        state    <= is_wr ? WDATA : RD_WAIT;
                    end
                end
                WDATA: begin
                    if (rx_hs) begin
                        o_wdata <= wdata_shift[DATAW-1:0];
                        if (byte_cnt == CNTW'(NB - 1)) begin
                            o_we  <= 1'b1;
                            state <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: state <= IDLE;
                RD_WAIT: begin
                    if (lat_cnt == '0)
                        state <= TX;
                    else
                        lat_cnt <= lat_cnt - 1'b1;
                end
                TX: begin
                    if (tx_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    regbus_tx_ser #(
        .DATAW(DATAW)
    ) u_tx_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .load    (tx_load),
        .word    (i_rdata),
        .tx_valid(o_tx_valid),
        .tx_data (o_tx_data),
        .tx_ready(i_tx_ready),
        .done    (tx_done)
    );

endmodule
